// File: rtl/datapath_player_pkg.sv
// Shared screen geometry, ship placement constants and move decode for the player datapath.
package datapath_player_pkg;

  localparam logic [7:0] SCREEN_W  = 8'd160;
  localparam logic [6:0] SCREEN_H  = 7'd120;
  localparam logic [1:0] SHIP_W    = 2'd2;
  localparam logic [6:0] SHIP_H    = 7'd3;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam logic [7:0] X_POS     = 8'd10;
  localparam logic [6:0] Y_INIT    = 7'd58;
  localparam logic [6:0] Y_MIN     = 7'd0;
  localparam logic [6:0] Y_MAX     = SCREEN_H - SHIP_H;
  localparam logic [6:0] STEP      = 7'd1;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_UP   = 2'd1,
    MV_DOWN = 2'd2
  } move_e;

  // Conflicting strobes cancel so the ship never jitters.
  function automatic move_e decode_move(input logic up, input logic down);
    move_e m;
    case ({up, down})
      2'b10:   m = MV_UP;
      2'b01:   m = MV_DOWN;
      default: m = MV_HOLD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/datapath_player_if.sv
// Control-FSM <-> player datapath bundle: move strobes, sprite pixel request, VGA pixel and ship status.
interface datapath_player_if;
  import datapath_player_pkg::*;

  logic       y_pos_mod;
  logic       y_neg_mod;
  logic       add_x;
  logic [1:0] add_y;
  logic [2:0] colour;
  logic       write_en;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic [6:0] ship_y;
  logic       at_top;
  logic       at_bottom;

  modport master (
    output y_pos_mod, y_neg_mod, add_x, add_y, colour, write_en,
    input  x_out, y_out, colour_out, plot, ship_y, at_top, at_bottom
  );

  modport slave (
    input  y_pos_mod, y_neg_mod, add_x, add_y, colour, write_en,
    output x_out, y_out, colour_out, plot, ship_y, at_top, at_bottom
  );

endinterface

// File: rtl/datapath_player_sat_step.sv
// Combinational saturating +/-STEP on the ship's top row, clamped to [Y_MIN, Y_MAX].
module datapath_player_sat_step
  import datapath_player_pkg::*;
(
  input  logic [6:0] i_y,
  input  move_e      i_move,
  output logic [6:0] o_y_next
);

  logic [7:0] w_y8;
  logic [7:0] w_lo_lim;
  logic [7:0] w_hi_lim;

  // Widened to 8 bits so STEP arithmetic near either bound cannot wrap.
  assign w_y8     = {1'b0, i_y};
  assign w_lo_lim = {1'b0, Y_MIN} + {1'b0, STEP};
  assign w_hi_lim = {1'b0, Y_MAX} - {1'b0, STEP};

  always_comb begin
    o_y_next = i_y;
    case (i_move)
      MV_UP: begin
        if (w_y8 < w_lo_lim) o_y_next = Y_MIN;
        else                 o_y_next = i_y - STEP;
      end
      MV_DOWN: begin
        if (w_y8 > w_hi_lim) o_y_next = Y_MAX;
        else                 o_y_next = i_y + STEP;
      end
      default: o_y_next = i_y;
    endcase
  end

endmodule

// File: rtl/datapath_player.sv
// Player datapath: ship row register plus a one-cycle pixel stage that turns sprite
// offsets into absolute VGA coordinates.
module datapath_player
  import datapath_player_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  datapath_player_if.slave   bus
);

  logic [6:0] r_ship_y;
  logic       r_at_top;
  logic       r_at_bottom;
  logic [7:0] r_x_out;
  logic [6:0] r_y_out;
  logic [2:0] r_colour_out;
  logic       r_plot;

  logic [6:0] w_y_next;
  move_e      w_move;
  logic       w_draw;

  assign w_move = decode_move(bus.y_pos_mod, bus.y_neg_mod);
  assign w_draw = bus.write_en && (bus.add_y != 2'd3);

  datapath_player_sat_step u_sat_step (
    .i_y      (r_ship_y),
    .i_move   (w_move),
    .o_y_next (w_y_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ship_y    <= Y_INIT;
      r_at_top    <= (Y_INIT == Y_MIN);
      r_at_bottom <= (Y_INIT == Y_MAX);
    end else begin
      r_ship_y    <= w_y_next;
      r_at_top    <= (w_y_next == Y_MIN);
      r_at_bottom <= (w_y_next == Y_MAX);
    end
  end

  // Pixel rows are taken from y_next so a move and the draw in the same cycle agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_out      <= 8'd0;
      r_y_out      <= 7'd0;
      r_colour_out <= 3'd0;
      r_plot       <= 1'b0;
    end else if (w_draw) begin
      r_x_out      <= X_POS + {7'd0, bus.add_x};
      r_y_out      <= w_y_next + {5'd0, bus.add_y};
      r_colour_out <= bus.colour;
      r_plot       <= 1'b1;
    end else begin
      r_plot       <= 1'b0;
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour_out;
  assign bus.plot       = r_plot;
  assign bus.ship_y     = r_ship_y;
  assign bus.at_top     = r_at_top;
  assign bus.at_bottom  = r_at_bottom;

endmodule
